// File: rtl/face_coord_collector_pkg.sv
// Shared definitions for the face coordinate collector: pyramid geometry,
// per-level scale table, FIFO entry layout and the collector state encoding.
package face_coord_collector_pkg;

    localparam int PYRAMID_LEVELS = 10;
    localparam int WINDOW_SIZE    = 24;
    localparam int COORD_W        = 32;
    localparam int CNT_W          = 16;

    // Q16.16 factors mapping a level's pixel grid back to the original image;
    // each one is the inverse of the downscaler's x_ratio for that level.
    localparam logic [31:0] LEVEL_SCALE [PYRAMID_LEVELS] = '{
        32'h0001_0000,  // 1.00
        32'h0001_4000,  // 1.25
        32'h0001_C000,  // 1.75
        32'h0002_4000,  // 2.25
        32'h0003_0000,  // 3.00
        32'h0004_0000,  // 4.00
        32'h0005_4000,  // 5.25
        32'h0007_0000,  // 7.00
        32'h0009_4000,  // 9.25
        32'h000C_4000   // 12.25
    };

    // One FIFO slot: four coordinates plus the frame-marker flag.
    typedef struct packed {
        logic [3:0][COORD_W-1:0] coords;
        logic                    last;
    } face_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_MARK    = 2'd2
    } state_e;

    // Table lookup that never indexes past the table; unknown levels give 0.
    function automatic logic [31:0] scale_lookup(input logic [3:0] lvl);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < PYRAMID_LEVELS; i++) begin
            if (lvl == 4'(i)) begin
                r = LEVEL_SCALE[i];
            end
        end
        return r;
    endfunction

    // Saturating increment of a frame counter by 0..3.
    function automatic logic [CNT_W-1:0] sat_add16(input logic [CNT_W-1:0] a,
                                                   input logic [1:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/face_coord_collector_result_fifo.sv
// Show-ahead FIFO with a registered head: rdata/valid are flops that always
// hold the oldest entry, so the consumer sees them straight from registers.
module result_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 129,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             valid,
    output logic [CW-1:0]    count
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    post_pop;
    logic [WIDTH-1:0] head_q, head_d;
    logic             valid_q, valid_d;
    logic             pop_ok, push_ok;

    // Occupancy bookkeeping; a push into a full FIFO is legal when a pop
    // frees a slot in the same cycle.
    always_comb begin
        pop_ok   = pop && (count_q != '0);
        post_pop = count_q - CW'(pop_ok);
        push_ok  = push && (post_pop < DEPTH_C);
        count_d  = post_pop + CW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        valid_d  = (count_d != '0);
        head_d   = head_q;
        if (post_pop != '0) begin
            head_d = mem_q[rd_ptr_d];
        end else if (push_ok) begin
            head_d = wdata;
        end
    end

    // Entry storage, kept free of reset so it maps onto RAM.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointers, count and registered head.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
        end
    end

    assign rdata = head_q;
    assign valid = valid_q;
    assign count = count_q;

endmodule

// File: rtl/multiplier.sv
// Unsigned WIDTH x WIDTH -> 2*WIDTH combinational multiplier.
module multiplier #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product
);

    assign product = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

endmodule

// File: rtl/face_coord_collector.sv
// Collects Viola-Jones window hits, scales them to original-image
// coordinates through a 2-stage pipeline, buffers them in a show-ahead FIFO
// and closes each frame with a marker entry carrying accepted/dropped counts.
module face_coord_collector
    import face_coord_collector_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int NUM_LEVELS = PYRAMID_LEVELS,
    parameter int WIN_SIZE   = WINDOW_SIZE
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     frame_start,
    input  logic                     frame_done,
    input  logic                     hit_valid,
    input  logic [3:0]               hit_level,
    input  logic [31:0]              hit_row,
    input  logic [31:0]              hit_col,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0][COORD_W-1:0]  face_coords,
    output logic                     out_last,
    output logic                     busy
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = $bits(face_entry_t);
    // Hits may only fill up to DEPTH-1 so the marker always has a slot.
    localparam logic [CW-1:0] HIT_LIMIT  = CW'(DEPTH - 1);
    localparam logic [CW-1:0] MARK_LIMIT = CW'(DEPTH);
    localparam logic [1:0]    MARK_WAIT  = 2'd2;

    state_e            state_q, state_d;
    logic [1:0]        mark_cnt_q, mark_cnt_d;
    logic [CNT_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  drop_q, drop_d;

    logic              s1_valid_q, s1_valid_d;
    logic [31:0]       s1_row_q, s1_col_q, s1_scale_q;
    logic              s2_valid_q, s2_valid_d;
    logic [31:0]       s2_x_q, s2_y_q, s2_wh_q;
    logic [31:0]       s2_x_d, s2_y_d, s2_wh_d;

    logic [31:0]       mul_a [3];
    logic [63:0]       mul_p [3];

    logic              collect_hit, level_ok, bad_level, flush;
    logic              pop;
    logic [CW-1:0]     fifo_count, post_pop;
    logic              hit_write, hit_fail, marker_write;
    logic              fifo_push;
    face_entry_t       hit_entry, marker_entry, push_entry, head_entry;
    logic [EW-1:0]     fifo_rdata;
    logic              fifo_valid;

    // Stage-2 products: column, row and window side each times the level scale.
    assign mul_a[0] = s1_col_q;
    assign mul_a[1] = s1_row_q;
    assign mul_a[2] = 32'(WIN_SIZE);

    for (genvar gi = 0; gi < 3; gi++) begin : g_mul
        multiplier #(.WIDTH(32)) u_mul (
            .a       (mul_a[gi]),
            .b       (s1_scale_q),
            .product (mul_p[gi])
        );
    end

    // Hit qualification, pipeline advance and FIFO write arbitration.
    always_comb begin
        collect_hit  = (state_q == ST_COLLECT) && hit_valid && !frame_start;
        level_ok     = int'(hit_level) < NUM_LEVELS;
        bad_level    = collect_hit && !level_ok;
        flush        = (state_q == ST_COLLECT) && frame_start;
        s1_valid_d   = collect_hit && level_ok;
        s2_valid_d   = s1_valid_q && !flush;
        s2_x_d       = 32'(mul_p[0] >> 16);
        s2_y_d       = 32'(mul_p[1] >> 16);
        s2_wh_d      = 32'(mul_p[2] >> 16);

        pop          = fifo_valid && out_ready;
        post_pop     = fifo_count - CW'(pop);
        hit_write    = s2_valid_q && (post_pop < HIT_LIMIT);
        hit_fail     = s2_valid_q && !(post_pop < HIT_LIMIT);
        marker_write = (state_q == ST_MARK) && (mark_cnt_q == MARK_WAIT)
                       && (post_pop < MARK_LIMIT);

        hit_entry.coords[0] = s2_x_q;
        hit_entry.coords[1] = s2_y_q;
        hit_entry.coords[2] = s2_wh_q;
        hit_entry.coords[3] = s2_wh_q;
        hit_entry.last      = 1'b0;

        marker_entry.coords[0] = {{(32-CNT_W){1'b0}}, acc_q};
        marker_entry.coords[1] = {{(32-CNT_W){1'b0}}, drop_q};
        marker_entry.coords[2] = '0;
        marker_entry.coords[3] = '0;
        marker_entry.last      = 1'b1;

        fifo_push  = hit_write || marker_write;
        push_entry = marker_write ? marker_entry : hit_entry;
    end

    // Frame counters: cleared on every accepted frame_start, otherwise bumped
    // by pipeline outcomes and out-of-range levels.
    always_comb begin
        acc_d  = acc_q;
        drop_d = drop_q;
        if (frame_start && (state_q != ST_MARK)) begin
            acc_d  = '0;
            drop_d = '0;
        end else begin
            acc_d  = sat_add16(acc_q, {1'b0, hit_write});
            drop_d = sat_add16(drop_q, {1'b0, bad_level} + {1'b0, hit_fail});
        end
    end

    // Next-state logic: MARK idles two cycles so in-flight hits land and get
    // counted before the marker is written.
    always_comb begin
        state_d    = state_q;
        mark_cnt_d = mark_cnt_q;
        case (state_q)
            ST_IDLE: begin
                mark_cnt_d = '0;
                if (frame_start) begin
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                mark_cnt_d = '0;
                if (!frame_start && frame_done) begin
                    state_d = ST_MARK;
                end
            end
            ST_MARK: begin
                if (mark_cnt_q != MARK_WAIT) begin
                    mark_cnt_d = mark_cnt_q + 2'd1;
                end else if (marker_write) begin
                    state_d    = ST_IDLE;
                    mark_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                mark_cnt_d = '0;
            end
        endcase
    end

    // State, counters and scale pipeline registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mark_cnt_q <= '0;
            acc_q      <= '0;
            drop_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_row_q   <= '0;
            s1_col_q   <= '0;
            s1_scale_q <= '0;
            s2_valid_q <= 1'b0;
            s2_x_q     <= '0;
            s2_y_q     <= '0;
            s2_wh_q    <= '0;
        end else begin
            state_q    <= state_d;
            mark_cnt_q <= mark_cnt_d;
            acc_q      <= acc_d;
            drop_q     <= drop_d;
            s1_valid_q <= s1_valid_d;
            s1_row_q   <= hit_row;
            s1_col_q   <= hit_col;
            s1_scale_q <= scale_lookup(hit_level);
            s2_valid_q <= s2_valid_d;
            s2_x_q     <= s2_x_d;
            s2_y_q     <= s2_y_d;
            s2_wh_q    <= s2_wh_d;
        end
    end

    result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_result_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (fifo_rdata),
        .valid (fifo_valid),
        .count (fifo_count)
    );

    assign head_entry  = face_entry_t'(fifo_rdata);
    assign out_valid   = fifo_valid;
    assign face_coords = head_entry.coords;
    assign out_last    = head_entry.last;
    assign busy        = (state_q != ST_IDLE) || fifo_valid;

endmodule

// File: tb/tb_face_coord_collector.sv
// Directed bench for face_coord_collector: scaling, latency, drop rule,
// marker contents/ordering, frame abandonment and asynchronous reset.
module tb_face_coord_collector;
    import face_coord_collector_pkg::*;

    logic                    clock = 1'b0;
    logic                    reset = 1'b1;
    logic                    frame_start = 1'b0;
    logic                    frame_done = 1'b0;
    logic                    hit_valid = 1'b0;
    logic [3:0]              hit_level = '0;
    logic [31:0]             hit_row = '0;
    logic [31:0]             hit_col = '0;
    logic                    out_ready = 1'b0;
    logic                    out_valid;
    logic                    out_last;
    logic                    busy;
    logic [3:0][31:0]        face_coords;

    int check_cnt = 0;
    int pass_cnt  = 0;

    always #5 clock = ~clock;

    face_coord_collector #(.DEPTH(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .hit_valid   (hit_valid),
        .hit_level   (hit_level),
        .hit_row     (hit_row),
        .hit_col     (hit_col),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .face_coords (face_coords),
        .out_last    (out_last),
        .busy        (busy)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        assert (got === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    task automatic chk_entry(input string tag, input int x, input int y,
                             input int w, input int h, input logic last);
        $display("entry %s: x=%0d y=%0d w=%0d h=%0d last=%0b", tag,
                 face_coords[0], face_coords[1], face_coords[2], face_coords[3], out_last);
        chk({tag, ".x"}, face_coords[0], 32'(x));
        chk({tag, ".y"}, face_coords[1], 32'(y));
        chk({tag, ".w"}, face_coords[2], 32'(w));
        chk({tag, ".h"}, face_coords[3], 32'(h));
        chk({tag, ".last"}, {31'd0, out_last}, {31'd0, last});
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic pulse_done();
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
    endtask

    task automatic send_hit(input logic [3:0] lvl, input int row, input int col);
        hit_valid = 1'b1;
        hit_level = lvl;
        hit_row   = 32'(row);
        hit_col   = 32'(col);
        step();
        hit_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, " valid within bound"}, {31'd0, out_valid}, 32'd1);
    endtask

    // Drains with out_ready=1; level-0 hits are expected as row=first_row+k,
    // col=row+100, followed by the marker.
    task automatic drain(input string tag, input int exp_hits, input int first_row,
                         input int acc, input int drop);
        int  hits = 0;
        bit  seen = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 60 && !seen; n++) begin
            if (out_valid) begin
                if (out_last) begin
                    chk_entry({tag, " marker"}, acc, drop, 0, 0, 1'b1);
                    seen = 1'b1;
                end else begin
                    chk_entry({tag, " hit"}, first_row + hits + 100, first_row + hits,
                              24, 24, 1'b0);
                    hits++;
                end
            end
            step();
        end
        chk({tag, " marker seen"}, {31'd0, seen}, 32'd1);
        chk({tag, " hit count"}, 32'(hits), 32'(exp_hits));
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst out_last", {31'd0, out_last}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst coords0", face_coords[0], 32'd0);
        chk("rst coords3", face_coords[3], 32'd0);
        reset = 1'b0;
        step();

        // Test 1: single level-0 hit, exact latency of hit and marker
        out_ready = 1'b1;
        pulse_start();
        chk("t1 busy in collect", {31'd0, busy}, 32'd1);
        hit_valid = 1'b1; hit_level = 4'd0; hit_row = 32'd10; hit_col = 32'd20;
        step();
        hit_valid = 1'b0;
        chk("t1 lat N", {31'd0, out_valid}, 32'd0);
        step();
        chk("t1 lat N+1", {31'd0, out_valid}, 32'd0);
        step();
        chk("t1 lat N+2", {31'd0, out_valid}, 32'd1);
        chk_entry("t1 hit", 20, 10, 24, 24, 1'b0);
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
        chk("t1 mark M", {31'd0, out_valid}, 32'd0);
        step();
        step();
        chk("t1 mark M+2", {31'd0, out_valid}, 32'd0);
        step();
        chk("t1 mark M+3", {31'd0, out_valid}, 32'd1);
        chk_entry("t1 marker", 1, 0, 0, 0, 1'b1);
        step();
        chk("t1 idle busy", {31'd0, busy}, 32'd0);

        // Test 2: level 2 scale 1.75, plus an out-of-range level
        pulse_start();
        send_hit(4'd2, 8, 16);
        send_hit(4'd15, 1, 1);
        pulse_done();
        wait_valid("t2 hit");
        chk_entry("t2 hit", 28, 14, 42, 42, 1'b0);
        step();
        wait_valid("t2 marker");
        chk_entry("t2 marker", 1, 1, 0, 0, 1'b1);
        step();

        // Test 3: stalled consumer, 20 hits into DEPTH=16
        out_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 20; i++) send_hit(4'd0, i, i + 100);
        pulse_done();
        repeat (6) step();
        chk("t3 valid", {31'd0, out_valid}, 32'd1);
        chk("t3 busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 50; i++) begin
            chk("t3 stable x", face_coords[0], 32'd100);
            chk("t3 stable valid", {31'd0, out_valid}, 32'd1);
            step();
        end
        drain("t3", 15, 0, 15, 5);

        // Test 4: hit and frame_done in the same cycle
        pulse_start();
        hit_valid = 1'b1; hit_level = 4'd0; hit_row = 32'd3; hit_col = 32'd103;
        frame_done = 1'b1;
        step();
        hit_valid = 1'b0;
        frame_done = 1'b0;
        drain("t4", 1, 3, 1, 0);

        // Test 5: frame abandoned after 3 hits, restarted with 2 hits
        out_ready = 1'b0;
        pulse_start();
        for (int r = 1; r <= 3; r++) send_hit(4'd0, r, r + 100);
        repeat (4) step();
        pulse_start();
        for (int r = 4; r <= 5; r++) send_hit(4'd0, r, r + 100);
        pulse_done();
        drain("t5", 5, 1, 2, 0);

        // Test 6: asynchronous reset with 4 entries buffered
        out_ready = 1'b0;
        pulse_start();
        for (int r = 0; r < 4; r++) send_hit(4'd0, r, r + 100);
        repeat (4) step();
        chk("t6 pre valid", {31'd0, out_valid}, 32'd1);
        chk("t6 pre busy", {31'd0, busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6 async valid", {31'd0, out_valid}, 32'd0);
        chk("t6 async busy", {31'd0, busy}, 32'd0);
        chk("t6 async last", {31'd0, out_last}, 32'd0);
        chk("t6 async coords0", face_coords[0], 32'd0);
        step();
        reset = 1'b0;
        step();
        out_ready = 1'b1;
        pulse_start();
        send_hit(4'd0, 7, 107);
        pulse_done();
        drain("t6", 1, 7, 1, 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/face_coord_collector.md
# face_coord_collector

Downstream of the Viola-Jones pipeline and the top-level scan FSM. Captures each window hit (pyramid level, row, column), converts it to original-image coordinates using per-level Q16.16 scale factors, and buffers the results in a show-ahead FIFO. Drains them over a valid/ready handshake to the UART transmit path. Closes every frame with a summary marker entry so the laptop knows when a frame's results are complete.

## Interface
Parameters:
- DEPTH, 16, FIFO entries (power of two, ≥4)
- PYRAMID_LEVELS, 10, number of pyramid levels (from shared package)
- WINDOW_SIZE, 24, scan window side in pixels

Ports:
- clock  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- frame_start  in  1  pulse; new frame scan begins
- frame_done  in  1  pulse; scan FSM and vj_pipeline fully flushed
- hit_valid  in  1  detection present this cycle
- hit_level  in  4  pyramid level of hit, 0..PYRAMID_LEVELS-1
- hit_row  in  32  window top-left row at that level
- hit_col  in  32  window top-left column at that level
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer accepts head entry
- face_coords  out  4×32  [0]=x, [1]=y, [2]=w, [3]=h (original-image pixels); marker: [0]=faces accepted, [1]=hits dropped, [2]=[3]=0
- out_last  out  1  head entry is the frame marker
- busy  out  1  state ≠ IDLE or FIFO non-empty

## Operation
- States: IDLE, COLLECT, MARK. Reset → IDLE.
- IDLE: hits are ignored. frame_start → COLLECT and clears the frame counters (accepted, dropped; 16-bit, saturating).
- COLLECT: each hit_valid enters the 2-stage scale pipeline.
  - Stage 1 registers the hit and looks up scale[hit_level].
  - Stage 2 computes x=(col·scale)>>16, y=(row·scale)>>16, w=h=(WINDOW_SIZE·scale)>>16, using 32×32→64-bit products with the low 32 bits kept after the shift. It then attempts a FIFO write.
- Drop rule: a hit is written only if the post-pop occupancy is < DEPTH-1. One slot is always kept for the marker. A write that fails increments dropped; a write that succeeds increments accepted.
- hit_level ≥ PYRAMID_LEVELS: the hit is discarded and counted as dropped.
- frame_done in COLLECT → MARK.
  - MARK waits for the pipeline to drain (2 cycles), then writes the marker using final counters that include all in-flight hits, and returns to IDLE.
  - If the FIFO is full at that moment (only possible after back-to-back frames with a stalled consumer), MARK holds until a slot frees.
- hit_valid and frame_done in the same cycle: the hit belongs to the closing frame and is ordered before the marker.
- frame_start in COLLECT: the frame is abandoned. No marker is written, counters are cleared, in-flight hits are discarded, and the state stays COLLECT.
- frame_start in MARK: ignored. The scan FSM must not start a frame while busy.
- FIFO: show-ahead. A pop occurs when out_valid && out_ready. Push and pop in the same cycle when full is legal for the marker; occupancy is unchanged.

## Timing
- Hit at edge N is visible at the FIFO head no earlier than edge N+2, when out_valid rises after that edge if the FIFO was empty.
- frame_done at edge N, with no stall: the marker is written at edge N+3.
- Outputs are registered and come straight from the FIFO head.
- Reset values: out_valid=0, face_coords=0, out_last=0, busy=0. The FIFO, pipeline and counters are all cleared.
- Reset mid-operation discards everything immediately, asynchronously.
- out_valid and face_coords stay stable while out_valid && !out_ready.

## Structure
- Shared package holds:
  - PYRAMID_LEVELS, WINDOW_SIZE
  - the level_scale array (Q16.16, the inverse of the downscaler x_ratios)
  - the face_entry_t struct {coords[4][32], last}
  - the state enum
- One sub-module: result_fifo. It is a parameterized show-ahead FIFO with count output, used for entry storage.
- Multipliers use the existing multiplier module.

## Test plan
- Single hit level 0 (scale 0x10000), row 10, col 20, out_ready=1 → one entry {20,10,24,24}, out_last=0; then after frame_done, marker {1,0,0,0}, out_last=1.
- Hit level 2 with scale 0x1C000 (1.75), row 8, col 16 → {28,14,42,42}.
- DEPTH=16, out_ready=0, 20 hits → 15 stored; marker {15,5,0,0} occupies slot 16; out_valid stays high and head stable for 50 cycles.
- hit_valid with frame_done same cycle, FIFO empty → hit entry precedes marker; marker reports accepted=1.
- frame_start mid-frame after 3 hits, then 2 hits and frame_done → 5 hit entries drained but marker {2,0,0,0}. The in-flight hits of the abandoned frame are not written, so the bench must space the restart ≥2 cycles after the last old hit.
- Assert reset while 4 entries are buffered and out_ready=0 → out_valid=0 and busy=0 immediately. The next frame starts with counters at 0.
